// File: rtl/free_reg_release_buffer.sv
// Purpose : buffers up to two freed physical register tags per cycle from commit and drains them in order, one per cycle, into the free list.
// Latency : a tag written in cycle N is presented on push_data no earlier than cycle N+1, because there is no same-cycle bypass.
// Backpressure: rel_ready falls once occupancy reaches DEPTH-1; the buffer holds its contents while fl_ready is low.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   rel_valid_1/rel_preg_1 commit slot 1 release (slot 1 is always ordered before slot 2)
//   rel_valid_2/rel_preg_2 commit slot 2 release
//   rel_ready              room for two tags this cycle (depends only on cnt)
//   push/push_data/fl_ready single-entry push channel to free_list
//   occupancy/empty        current entry count and empty flag
module free_reg_release_buffer #(
    parameter int DATA_WIDTH = 7,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rel_valid_1,
    input  logic [DATA_WIDTH-1:0] rel_preg_1,
    input  logic                  rel_valid_2,
    input  logic [DATA_WIDTH-1:0] rel_preg_2,
    output logic                  rel_ready,
    output logic [DATA_WIDTH-1:0] push_data,
    output logic                  push,
    input  logic                  fl_ready,
    output logic [CNT_W-1:0]      occupancy,
    output logic                  empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_acc_1;
    logic                  w_acc_2;
    logic                  w_pop;
    logic [1:0]            w_n_in;
    logic [PTR_W-1:0]      w_wr_ptr_p1;
    logic [PTR_W-1:0]      w_slot2_ptr;

    assign empty     = (r_cnt == '0);
    assign occupancy = r_cnt;
    // Two free slots are required so that a dual release can never overflow.
    assign rel_ready = (r_cnt <= CNT_W'(DEPTH - 2));
    assign push      = ~empty & fl_ready;
    assign w_pop     = push;
    assign push_data = empty ? '0 : r_mem[r_rd_ptr];

    assign w_acc_1     = rel_ready & rel_valid_1;
    assign w_acc_2     = rel_ready & rel_valid_2;
    assign w_n_in      = {1'b0, w_acc_1} + {1'b0, w_acc_2};
    assign w_wr_ptr_p1 = r_wr_ptr + PTR_W'(1);
    // Slot 2 lands behind slot 1 when both fire, otherwise at the write pointer itself.
    assign w_slot2_ptr = w_acc_1 ? w_wr_ptr_p1 : r_wr_ptr;

    // Storage array is intentionally not reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_acc_1) r_mem[r_wr_ptr]    <= rel_preg_1;
            if (w_acc_2) r_mem[w_slot2_ptr] <= rel_preg_2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_in);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_cnt    <= r_cnt + CNT_W'(w_n_in) - CNT_W'(w_pop);
        end
    end

    a_rel_on_full: assert property (@(posedge clk) disable iff (rst)
        (rel_valid_1 | rel_valid_2) |-> rel_ready)
        else $fatal(1, "Release on full!");

    a_cnt_max: assert property (@(posedge clk) r_cnt <= CNT_W'(DEPTH));

    a_push_rdy: assert property (@(posedge clk) push |-> fl_ready);

    a_no_underflow: assert property (@(posedge clk) w_pop |-> !empty);

endmodule

// File: tb/tb_free_reg_release_buffer.sv
// Purpose : directed self-checking bench for free_reg_release_buffer with an in-order expected-tag queue.
// Latency : inputs are applied after each rising edge and outputs are sampled 1 time unit later.
// Backpressure: releases are only offered while the expected occupancy leaves room for two tags.
module tb_free_reg_release_buffer;
    logic       clk;
    logic       rst;
    logic       rel_valid_1;
    logic [6:0] rel_preg_1;
    logic       rel_valid_2;
    logic [6:0] rel_preg_2;
    logic       rel_ready;
    logic [6:0] push_data;
    logic       push;
    logic       fl_ready;
    logic [4:0] occupancy;
    logic       empty;

    int         n_checks;
    int         n_errs;
    logic [6:0] exp_q [$];
    logic [6:0] tag;
    int         max_occ;

    free_reg_release_buffer #(.DATA_WIDTH(7), .DEPTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rel_valid_1 (rel_valid_1),
        .rel_preg_1  (rel_preg_1),
        .rel_valid_2 (rel_valid_2),
        .rel_preg_2  (rel_preg_2),
        .rel_ready   (rel_ready),
        .push_data   (push_data),
        .push        (push),
        .fl_ready    (fl_ready),
        .occupancy   (occupancy),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag_s, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag_s, act, exp);
        end
    endtask

    // One cycle: apply inputs, check outputs against the expected queue, update the queue, then clock.
    task automatic drive(input logic v1, input logic [6:0] p1,
                         input logic v2, input logic [6:0] p2, input logic fr);
        rel_valid_1 = v1;
        rel_preg_1  = p1;
        rel_valid_2 = v2;
        rel_preg_2  = p2;
        fl_ready    = fr;
        #1;
        check_eq("occupancy", int'(occupancy), exp_q.size());
        check_eq("rel_ready", int'(rel_ready), int'(exp_q.size() <= 14));
        check_eq("empty", int'(empty), int'(exp_q.size() == 0));
        check_eq("push", int'(push), int'(exp_q.size() != 0 && fr));
        if (exp_q.size() != 0) check_eq("push_data", int'(push_data), int'(exp_q[0]));
        else                   check_eq("push_data_idle", int'(push_data), 0);
        if (exp_q.size() > max_occ) max_occ = exp_q.size();
        if (exp_q.size() != 0 && fr) void'(exp_q.pop_front());
        if (v1) exp_q.push_back(p1);
        if (v2) exp_q.push_back(p2);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_errs      = 0;
        max_occ     = 0;
        rst         = 1'b1;
        rel_valid_1 = 1'b0;
        rel_preg_1  = '0;
        rel_valid_2 = 1'b0;
        rel_preg_2  = '0;
        fl_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_occupancy", int'(occupancy), 0);
        check_eq("rst_empty", int'(empty), 1);
        check_eq("rst_push", int'(push), 0);
        check_eq("rst_rel_ready", int'(rel_ready), 1);
        check_eq("rst_push_data", int'(push_data), 0);
        rst = 1'b0;

        // Single release: no bypass in the write cycle, tag 40 appears one cycle later.
        drive(1'b1, 7'd40, 1'b0, 7'd0, 1'b1);
        check_eq("t1_push", int'(push), 1);
        check_eq("t1_push_data", int'(push_data), 40);
        drive(1'b0, 7'd0, 1'b0, 7'd0, 1'b1);
        check_eq("t1_empty_after", int'(empty), 1);

        // Dual release: 41 then 42, occupancy 2 -> 1 -> 0.
        drive(1'b1, 7'd41, 1'b1, 7'd42, 1'b1);
        check_eq("t2_occ2", int'(occupancy), 2);
        check_eq("t2_first", int'(push_data), 41);
        drive(1'b0, 7'd0, 1'b0, 7'd0, 1'b1);
        check_eq("t2_occ1", int'(occupancy), 1);
        check_eq("t2_second", int'(push_data), 42);
        drive(1'b0, 7'd0, 1'b0, 7'd0, 1'b1);
        check_eq("t2_occ0", int'(occupancy), 0);

        // Fill with fl_ready low: 50..65, then drain in order.
        tag = 7'd50;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tag, 1'b1, tag + 7'd1, 1'b0);
            tag = tag + 7'd2;
        end
        check_eq("t3_full_occ", int'(occupancy), 16);
        check_eq("t3_full_rdy", int'(rel_ready), 0);
        check_eq("t3_hold_push", int'(push), 0);
        check_eq("t3_head", int'(push_data), 50);
        drive(1'b0, 7'd0, 1'b0, 7'd0, 1'b1);
        check_eq("t3_occ15_rdy", int'(rel_ready), 0);
        check_eq("t3_second", int'(push_data), 51);
        drive(1'b0, 7'd0, 1'b0, 7'd0, 1'b1);
        check_eq("t3_occ14_rdy", int'(rel_ready), 1);
        for (int i = 0; i < 14; i++) drive(1'b0, 7'd0, 1'b0, 7'd0, 1'b1);
        check_eq("t3_drained", int'(empty), 1);

        // Steady dual release with draining; commit throttled at 15, pointer wraps mid-pair.
        max_occ = 0;
        tag = 7'd64;
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() <= 14) begin
                drive(1'b1, tag, 1'b1, tag + 7'd1, 1'b1);
                tag = tag + 7'd2;
            end else begin
                drive(1'b0, 7'd0, 1'b0, 7'd0, 1'b1);
            end
        end
        check_eq("t4_max_occ", max_occ, 15);
        for (int i = 0; i < 16; i++) drive(1'b0, 7'd0, 1'b0, 7'd0, 1'b1);
        check_eq("t4_drained", int'(empty), 1);

        // Slot 2 only: 60 is pushed, 61 never is.
        drive(1'b0, 7'd61, 1'b1, 7'd60, 1'b1);
        check_eq("t5_occ", int'(occupancy), 1);
        check_eq("t5_data", int'(push_data), 60);
        drive(1'b0, 7'd0, 1'b0, 7'd0, 1'b1);
        drive(1'b0, 7'd0, 1'b0, 7'd0, 1'b1);
        check_eq("t5_empty", int'(empty), 1);

        // Reset mid-operation with releases presented during the reset cycle.
        drive(1'b1, 7'd1, 1'b1, 7'd2, 1'b0);
        drive(1'b1, 7'd3, 1'b1, 7'd4, 1'b0);
        drive(1'b1, 7'd5, 1'b0, 7'd0, 1'b0);
        check_eq("t6_loaded", int'(occupancy), 5);
        rst         = 1'b1;
        rel_valid_1 = 1'b1;
        rel_preg_1  = 7'd9;
        rel_valid_2 = 1'b1;
        rel_preg_2  = 7'd10;
        fl_ready    = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        rel_valid_1 = 1'b0;
        rel_valid_2 = 1'b0;
        exp_q.delete();
        check_eq("t6_occ", int'(occupancy), 0);
        check_eq("t6_empty", int'(empty), 1);
        check_eq("t6_push", int'(push), 0);
        for (int i = 0; i < 4; i++) drive(1'b0, 7'd0, 1'b0, 7'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/free_reg_release_buffer.md
Name: free_reg_release_buffer

Overview:
- Producer side of the free-list push channel.
- Collects physical register tags freed at commit (up to two per cycle, one per commit slot) and buffers them in an in-order circular FIFO.
- Drains the FIFO one tag per cycle into the free list's single-entry push/ready port.
- Sits between the commit stage and free_list; decouples dual-commit bursts from the free list's one-push-per-cycle limit.

Parameters:
- DATA_WIDTH, 7, physical register tag width; matches free_list DATA_WIDTH.
- DEPTH, 16, buffer entries; power of two, at least 4.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width; derived, do not override.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- rel_valid_1  input  1  commit slot 1 frees a register this cycle
- rel_preg_1  input  DATA_WIDTH  tag freed by slot 1
- rel_valid_2  input  1  commit slot 2 frees a register this cycle
- rel_preg_2  input  DATA_WIDTH  tag freed by slot 2
- rel_ready  output  1  buffer can accept two tags this cycle
- push_data  output  DATA_WIDTH  tag to free_list
- push  output  1  push strobe to free_list
- fl_ready  input  1  free_list ready (not full)
- occupancy  output  CNT_W  current entry count
- empty  output  1  occupancy == 0

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array, binary write pointer wr_ptr, read pointer rd_ptr, counter cnt. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Reset, synchronous on the rst cycle:
  - wr_ptr = rd_ptr = cnt = 0.
  - Outputs: push = 0, empty = 1, occupancy = 0, rel_ready = 1, push_data = 0.
  - The array is not cleared.
- rel_ready = (cnt <= DEPTH-2). It is combinational from cnt only and never depends on the current cycle's pop.
- Commit must not assert any rel_valid_x while rel_ready = 0. An SVA $fatal fires on violation: "Release on full!".
- Enqueue in a cycle where rel_ready = 1:
  - Only slot 1 valid: write rel_preg_1 at wr_ptr; wr_ptr += 1.
  - Only slot 2 valid: write rel_preg_2 at wr_ptr; wr_ptr += 1.
  - Both valid: rel_preg_1 at wr_ptr, rel_preg_2 at wr_ptr+1; wr_ptr += 2. Order slot 1 before slot 2 is mandatory.
- Dequeue:
  - push = ~empty & fl_ready.
  - push_data = mem[rd_ptr] when ~empty, else 0.
  - On push, rd_ptr += 1.
- Latency: a tag written in cycle N can be pushed no earlier than cycle N+1. There is no same-cycle bypass.
- Counter update: cnt_next = cnt + n_in - pop, where n_in is in {0,1,2} and pop is in {0,1}.
  - Simultaneous enqueue of 2 and pop of 1 gives a net +1.
  - Enqueue of 1 and pop of 1 leaves cnt unchanged.
- Empty, with a release arriving the same cycle: push = 0 that cycle. The tag appears the next cycle.
- Full region (cnt >= DEPTH-1): rel_ready = 0. Draining continues normally. rel_ready returns the cycle after cnt drops to DEPTH-2.
- fl_ready = 0: push is held low and the buffer holds its contents. push_data keeps presenting the head.
- Wrap-around: a double write at wr_ptr = DEPTH-1 puts slot 1 in entry DEPTH-1 and slot 2 in entry 0.
- Reset mid-operation: all buffered tags are discarded; the free list is re-initialised by the same reset. Releases presented during the rst cycle are ignored.
- Additional assertions:
  - cnt never exceeds DEPTH.
  - push implies fl_ready.
  - The buffer is never popped when empty.

Test Plan:
- Reset, then a single release rel_valid_1 = 1, rel_preg_1 = 40, with fl_ready = 1 -> push = 0 in the write cycle; push = 1 with push_data = 40 the next cycle; empty = 1 after that.
- Dual release (41, 42) in one cycle with fl_ready = 1 -> pushes of 41 then 42 on consecutive cycles; occupancy goes 0 -> 2 -> 1 -> 0.
- Hold fl_ready = 0 and issue dual releases every cycle starting at tag 50 -> occupancy climbs 2, 4, ... 14; rel_ready drops to 0 when occupancy reaches 16 (DEPTH = 16). Then set fl_ready = 1 -> tags come out 50, 51, ... in order; rel_ready returns once occupancy is 14.
- Steady state with dual release every cycle and fl_ready = 1 -> occupancy grows by 1 per cycle, and commit is throttled at 15/16. Order is preserved across pointer wrap: entries 15 and 0 are written in one cycle and popped in that order.
- Only slot 2 valid (rel_preg_2 = 60), with slot 1 invalid and rel_preg_1 = 61 -> only 60 is pushed; occupancy is at most 1.
- Load 5 entries, then assert rst for one cycle while presenting releases -> the next cycle has occupancy = 0, empty = 1, push = 0; no stale tags are pushed afterwards.
